// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter among NREQ message sequencers.
// A grant is held from its go pulse until the winner's done or an inactivity timeout.
module uart_tx_arbiter #(
   parameter int NREQ = 4,
   parameter int TIMEOUT = 1000000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ-1:0]   done_in,
   input  logic [8*NREQ-1:0] txdata_in,
   input  logic [NREQ-1:0]   ldtxdata_in,
   input  logic              txempty,
   output logic [NREQ-1:0]   go,
   output logic [NREQ-1:0]   gnt,
   output logic [NREQ-1:0]   txempty_out,
   output logic [7:0]        txdata,
   output logic              ldtxdata,
   output logic              busy,
   output logic              abort
);
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   typedef enum logic [1:0] {IDLE, GO, BUSY, REL} state_t;
   state_t state, nxt;
   logic [NREQ-1:0] pending;
   logic [PW-1:0] ptr, sel, win, idx;
   logic [CW-1:0] cnt;
   logic fire, expire, rel;
   assign fire = state == IDLE && |pending;
   assign expire = cnt == CW'(TIMEOUT - 1);
   assign rel = state == BUSY && (done_in[sel] || expire);
   // Descending scan so the lowest rotation offset from ptr wins.
   always_comb begin
      win = ptr;
      idx = ptr;
      for (int k = NREQ - 1; k >= 0; k--) begin
         idx = PW'((int'(ptr) + k) % NREQ);
         if (pending[idx]) win = idx;
      end
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) state <= IDLE;
      else state <= nxt;
   always_comb
      case (state)
         IDLE:    nxt = fire ? GO : IDLE;
         GO:      nxt = BUSY;
         BUSY:    nxt = rel ? REL : BUSY;
         default: nxt = IDLE;
      endcase
   // Release clears the winner's pending bit, but a req on the same edge re-pends it.
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         pending <= '0;
         ptr <= '0;
         sel <= '0;
         gnt <= '0;
         go <= '0;
         abort <= 1'b0;
         cnt <= '0;
      end else begin
         pending <= (pending & ~(rel ? NREQ'(1) << sel : '0)) | req;
         ptr <= rel ? (sel == PW'(NREQ - 1) ? '0 : sel + PW'(1)) : ptr;
         sel <= fire ? win : sel;
         gnt <= fire ? NREQ'(1) << win : rel ? '0 : gnt;
         go <= fire ? NREQ'(1) << win : '0;
         abort <= state == BUSY && !done_in[sel] && expire;
         cnt <= state == GO ? '0 : (state == BUSY && !rel) ? (ldtxdata_in[sel] ? '0 : cnt + CW'(1)) : cnt;
      end
   always_comb begin
      txdata = '0;
      for (int i = 0; i < NREQ; i++) txdata = txdata | (gnt[i] ? txdata_in[8*i +: 8] : 8'h00);
      ldtxdata = |(ldtxdata_in & gnt);
      txempty_out = gnt & {NREQ{txempty}};
      busy = state != IDLE;
   end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares the single UART transmitter (txdata/ldtxdata/txempty interface) between NREQ message-sequencer FSMs, such as the post-entry and status-report senders. Requesters post a one-cycle request. The arbiter grants round-robin, issues a start pulse to the winner, and muxes the winner's txdata/ldtxdata onto the UART. It routes txempty back to the winner only and releases the UART on the winner's done pulse or on an inactivity timeout.

Parameters:
NREQ, 4, number of requesting sequencers (2..8)
TIMEOUT, 1000000, max cycles in BUSY without a granted ldtxdata or done before forced release (>=2)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
req  in  NREQ  per-requester request pulse (level tolerated; merged while pending)
done_in  in  NREQ  per-requester done pulse (message finished)
txdata_in  in  8*NREQ  requester i's byte at bits [8i+7:8i]
ldtxdata_in  in  NREQ  requester load strobes
txempty  in  1  UART transmit-empty
go  out  NREQ  one-cycle start pulse to granted requester (drives its start)
gnt  out  NREQ  one-hot grant, held for the whole transaction
txempty_out  out  NREQ  txempty gated to granted requester; 0 to others
txdata  out  8  to UART
ldtxdata  out  1  to UART
busy  out  1  1 when state != IDLE
abort  out  1  one-cycle pulse on timeout release

Behaviour:
- Reset (async, immediate): state=IDLE, pending=0, ptr=0, gnt=0, go=0, abort=0, counter=0. Combinational outputs therefore read txdata=0, ldtxdata=0, txempty_out=0, busy=0.
- pending[i] is set at any edge where req[i]=1. It is cleared only on release of i. If a set and a clear land on the same edge, the set wins (re-pend).
- States:
  - IDLE:
    - pending!=0 -> GO.
    - Winner = first pending index searching ptr, ptr+1, ... mod NREQ.
    - Register gnt=onehot(winner) and go=onehot(winner).
  - GO (1 cycle):
    - go asserted.
    - -> BUSY; go<=0; counter<=0.
  - BUSY:
    - done_in[w]=1 -> REL.
    - Else if counter==TIMEOUT-1 -> REL with abort<=1.
    - Else counter increments; counter resets to 0 on any cycle with ldtxdata_in[w]=1.
  - REL (1 cycle):
    - gnt=0; pending[w] cleared; ptr<=(w+1) mod NREQ; abort is high this cycle only.
    - -> IDLE.
- Latency:
  - req at edge k -> gnt/go high after edge k+1.
  - done_in at edge m -> gnt low after edge m.
  - Next grant no earlier than after edge m+2.
- Datapath (combinational from registered gnt):
  - txdata = txdata_in[w], ldtxdata = ldtxdata_in[w], txempty_out[w] = txempty.
  - With no grant: all zero.
  - Requester byte/strobe timing reaches the UART unchanged (zero added latency).
- Strobes from non-granted requesters are ignored and never reach the UART.
- done_in outside BUSY, or from a non-granted index, is ignored.
- The timeout counter is wide enough for TIMEOUT-1 and never wraps.
- gnt is always one-hot or zero. go is a subset of gnt.

Test Plan:
1. NREQ=4, TIMEOUT=32. Pulse req[2] at edge 0:
   - gnt=4'b0100 and go=4'b0100 after edge 1; go=0 after edge 2.
   - txdata_in[2]=8'h22 with ldtxdata_in[2]=1 -> txdata=8'h22, ldtxdata=1 same cycle.
   - done_in[2] at edge 10 -> gnt=0 after edge 10, busy=0 after edge 11, ptr=3.
2. From reset, req=4'b1011 in one cycle:
   - Grants in order 0, 1, 3, each released by its done_in.
   - ptr=0 at end, and pending=0 at end.
3. Requester 1 granted; requester 3 drives ldtxdata_in[3]=1 with txdata_in[3]=8'h41:
   - ldtxdata=0 and txdata stays at requester 1's byte.
   - txempty=1 -> txempty_out=4'b0010.
4. Grant 2, no strobes and no done_in for 32 BUSY cycles:
   - abort pulses 1 cycle, gnt=0, pending[2]=0, ptr=3.
   - A pending req[0] is granted 2 cycles later.
5. Assert reset mid-BUSY:
   - gnt, go, ldtxdata, busy, abort all 0 immediately (before the next clk edge); pending cleared.
   - After deassertion, no grant without a new req.
6. req[0] and done_in[0] on the same edge while 0 is granted, with pending[1] set:
   - 0 is re-pended; 1 is granted next, then 0 again.
